altpcierd_cdma_rx_dispatch: RTL

RX TLP dispatcher for the chaining DMA application. Sits downstream of the Avalon-ST to descriptor/data RX adapter on the desc/data handshake (rx_req/rx_ack/rx_ws/rx_dv/rx_dfr). It decodes each received TLP header and steers the TLP to one of two clients: the completion client (DMA read completions) or the target client (memory requests). It discards every other TLP type itself, and discards a TLP whose client never acknowledges it.

---
 rtl/altpcierd_cdma_rx_dispatch.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/altpcierd_cdma_rx_dispatch.sv
// altpcierd_cdma_rx_dispatch
//   RX TLP dispatcher for the chaining DMA application. Decodes each TLP
//   descriptor from the RX adapter and steers it to the completion client
//   (Cpl/CplD) or the target client (MRd/MRdLk/MWr). It discards all other TLP
//   types itself, and discards any TLP whose client does not acknowledge it
//   within ACK_TIMEOUT cycles.
//
// Parameters
//   ACK_TIMEOUT   cycles a client may hold off its ack; 0 disables the timeout
//
// Ports
//   clk_in, srst                  clock, async active-high reset
//   rx_req/rx_desc/rx_ack/rx_ws   descriptor handshake with the RX adapter
//   rx_dfr/rx_dv/rx_data/rx_be    payload from the RX adapter
//   cpl_* / tgt_*                 client request/ack/ws and 1-cycle payload
//   drop_pulse                    one pulse per discarded TLP
//   cpl_cnt/tgt_cnt/drop_cnt      saturating statistics
//
// Build option
//   CDMA_RX_DISPATCH_STATS_EN     builds the statistics counters; without it
//                                 the three count outputs are tied to 0.
module altpcierd_cdma_rx_dispatch #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic         clk_in,
  input  logic         srst,
  input  logic         rx_req,
  input  logic [135:0] rx_desc,
  input  logic         rx_dfr,
  input  logic         rx_dv,
  input  logic [63:0]  rx_data,
  input  logic [7:0]   rx_be,
  output logic         rx_ack,
  output logic         rx_ws,
  output logic         cpl_req,
  output logic [135:0] cpl_desc,
  input  logic         cpl_ack,
  input  logic         cpl_ws,
  output logic         cpl_dv,
  output logic         cpl_dfr,
  output logic [63:0]  cpl_data,
  output logic [7:0]   cpl_be,
  output logic         tgt_req,
  output logic [135:0] tgt_desc,
  input  logic         tgt_ack,
  input  logic         tgt_ws,
  output logic         tgt_dv,
  output logic         tgt_dfr,
  output logic [63:0]  tgt_data,
  output logic [7:0]   tgt_be,
  output logic         drop_pulse,
  output logic [15:0]  cpl_cnt,
  output logic [15:0]  tgt_cnt,
  output logic [15:0]  drop_cnt
);

  // Counter only needs to reach ACK_TIMEOUT-1.
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_FWD, S_DATA, S_DISCARD, S_RELEASE} state_t;

  typedef struct packed {
    logic        dv;
    logic        dfr;
    logic [63:0] data;
    logic [7:0]  be;
  } beat_t;

  state_t        state, state_nxt;
  logic          sel_cpl;     // 1: completion client, 0: target client
  logic          has_pl;
  logic [TW-1:0] tmo_cnt;
  beat_t         rx_beat, cpl_q, tgt_q;

  logic [4:0] rx_type;
  logic       is_cpl, is_tgt;
  logic       sel_ack, sel_ws, tmo_hit, pl_done;
  logic       accept, enter_drop;

  assign rx_type = rx_desc[124:120];
  assign is_cpl  = (rx_type == 5'b01010);
  assign is_tgt  = (rx_type[4:1] == 4'b0000);
  assign sel_ack = sel_cpl ? cpl_ack : tgt_ack;
  assign sel_ws  = sel_cpl ? cpl_ws  : tgt_ws;
  assign tmo_hit = (ACK_TIMEOUT != 0) && (tmo_cnt == TMO_LAST);
  assign pl_done = !rx_dfr && !rx_dv;
  assign rx_beat = '{dv: rx_dv, dfr: rx_dfr, data: rx_data, be: rx_be};

  // An ack always beats a coincident timeout expiry.
  assign accept     = (state == S_FWD) && sel_ack;
  assign enter_drop = ((state == S_IDLE) && rx_req && !(is_cpl || is_tgt)) ||
                      ((state == S_FWD) && !sel_ack && tmo_hit);

  always_comb begin
    state_nxt = state;
    rx_ws     = 1'b1;
    cpl_req   = 1'b0;
    tgt_req   = 1'b0;
    case (state)
      S_IDLE:    if (rx_req) state_nxt = (is_cpl || is_tgt) ? S_FWD : S_DISCARD;
      S_FWD: begin
        cpl_req = sel_cpl;
        tgt_req = !sel_cpl;
        if (sel_ack)      state_nxt = has_pl ? S_DATA : S_RELEASE;
        else if (tmo_hit) state_nxt = S_DISCARD;
      end
      S_DATA: begin
        // Combinational so the adapter's registered ready sees no extra delay.
        rx_ws = sel_ws;
        if (pl_done) state_nxt = S_RELEASE;
      end
      S_DISCARD: begin
        rx_ws = 1'b0;
        if (pl_done) state_nxt = S_RELEASE;
      end
      // Hold until the adapter drops rx_req so one descriptor is never taken twice.
      S_RELEASE: if (!rx_req) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge srst) begin
    if (srst) begin
      state      <= S_IDLE;
      sel_cpl    <= 1'b0;
      has_pl     <= 1'b0;
      tmo_cnt    <= '0;
      rx_ack     <= 1'b0;
      drop_pulse <= 1'b0;
      cpl_desc   <= '0;
      tgt_desc   <= '0;
      cpl_q      <= '0;
      tgt_q      <= '0;
    end else begin
      state      <= state_nxt;
      rx_ack     <= accept || enter_drop;
      drop_pulse <= enter_drop;
      tmo_cnt    <= (state == S_FWD) ? tmo_cnt + 1'b1 : '0;
      if (state == S_IDLE && rx_req) begin
        sel_cpl <= is_cpl;
        has_pl  <= rx_desc[126];
        if (is_cpl) cpl_desc <= rx_desc;
        if (is_tgt) tgt_desc <= rx_desc;
      end
      cpl_q <= (state == S_DATA &&  sel_cpl) ? rx_beat : '0;
      tgt_q <= (state == S_DATA && !sel_cpl) ? rx_beat : '0;
    end
  end

  assign cpl_dv   = cpl_q.dv;
  assign cpl_dfr  = cpl_q.dfr;
  assign cpl_data = cpl_q.data;
  assign cpl_be   = cpl_q.be;
  assign tgt_dv   = tgt_q.dv;
  assign tgt_dfr  = tgt_q.dfr;
  assign tgt_data = tgt_q.data;
  assign tgt_be   = tgt_q.be;

`ifdef CDMA_RX_DISPATCH_STATS_EN
  // Bumped on the same edge that raises rx_ack, by outcome; saturating.
  always_ff @(posedge clk_in or posedge srst) begin
    if (srst) begin
      cpl_cnt  <= '0;
      tgt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (accept &&  sel_cpl && cpl_cnt  != 16'hFFFF) cpl_cnt  <= cpl_cnt  + 16'd1;
      if (accept && !sel_cpl && tgt_cnt  != 16'hFFFF) tgt_cnt  <= tgt_cnt  + 16'd1;
      if (enter_drop         && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
  assign cpl_cnt  = 16'h0;
  assign tgt_cnt  = 16'h0;
  assign drop_cnt = 16'h0;
`endif

endmodule
